// File: rtl/turret_aim_ctrl.sv
// Turret aiming controller: edge-detected keyboard stepping with hold-to-repeat,
// clamp/wrap limits, a home key and a fire-request handshake with frame cooldown.
module turret_aim_ctrl #(
  parameter int          NUM_ANGLES   = 9,
  parameter int          HOME_IDX     = 4,
  parameter int          WRAP         = 0,
  parameter logic [7:0]  KEY_UP       = 8'h1A,
  parameter logic [7:0]  KEY_DOWN     = 8'h16,
  parameter logic [7:0]  KEY_HOME     = 8'h4A,
  parameter logic [7:0]  KEY_FIRE     = 8'h2C,
  parameter int          REPEAT_DELAY = 30,
  parameter int          REPEAT_RATE  = 6,
  parameter int          COOLDOWN     = 20,
  localparam int         IDX_W        = (NUM_ANGLES > 1) ? $clog2(NUM_ANGLES) : 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  frame_tick,
  input  logic [7:0]            keycode,
  input  logic                  fire_ready,
  output logic [IDX_W-1:0]      angle_idx,
  output logic [NUM_ANGLES-1:0] angle_onehot,
  output logic                  step_pulse,
  output logic                  limit_hit,
  output logic                  fire_valid,
  output logic [IDX_W-1:0]      fire_angle,
  output logic [1:0]            dbg_state
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam int CD_W    = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [NUM_ANGLES-1:0] ONEHOT_ONE = 1;
  localparam logic [IDX_W-1:0]      IDX_TOP    = IDX_W'(NUM_ANGLES - 1);
  localparam logic [IDX_W-1:0]      IDX_HOME   = IDX_W'(HOME_IDX);

  // dbg_state encoding: 0 = IDLE, 1 = DELAY (waiting for first repeat), 2 = REPEAT
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  state_t           state, state_d;
  logic             dir, dir_d;            // 1 = up, 0 = down
  logic [RPT_W-1:0] rpt_cnt, rpt_cnt_d;
  logic [7:0]       key_prev;
  logic [CD_W-1:0]  cooldown;

  logic       press_up, press_down, press_home, press_fire;
  logic [7:0] dir_key;
  logic       opp_press;
  logic       do_step, step_up;
  logic       at_top, at_bottom;

  logic [IDX_W-1:0] idx_d;
  logic             step_pulse_d, limit_hit_d;

  assign press_up   = (keycode == KEY_UP)   && (key_prev != KEY_UP);
  assign press_down = (keycode == KEY_DOWN) && (key_prev != KEY_DOWN);
  assign press_home = (keycode == KEY_HOME) && (key_prev != KEY_HOME);
  assign press_fire = (keycode == KEY_FIRE) && (key_prev != KEY_FIRE);

  assign dir_key   = dir ? KEY_UP : KEY_DOWN;
  assign opp_press = dir ? press_down : press_up;

  assign at_top    = (angle_idx == IDX_TOP);
  assign at_bottom = (angle_idx == '0);

  assign angle_onehot = ONEHOT_ONE << angle_idx;
  assign dbg_state    = state;

  // Repeat FSM: decides whether a step happens this edge and in which direction.
  always_comb begin
    state_d   = state;
    dir_d     = dir;
    rpt_cnt_d = rpt_cnt;
    do_step   = 1'b0;
    step_up   = dir;
    if (press_home) begin
      state_d   = ST_IDLE;
      rpt_cnt_d = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (press_up || press_down) begin
            do_step   = 1'b1;
            step_up   = press_up;
            dir_d     = press_up;
            rpt_cnt_d = RPT_W'(REPEAT_DELAY);
            state_d   = ST_DELAY;
          end
        end
        ST_DELAY, ST_REPEAT: begin
          if (keycode != dir_key) begin
            // Rolling straight onto the opposite key restarts the delay in the new direction.
            if (opp_press) begin
              do_step   = 1'b1;
              step_up   = ~dir;
              dir_d     = ~dir;
              rpt_cnt_d = RPT_W'(REPEAT_DELAY);
              state_d   = ST_DELAY;
            end else begin
              rpt_cnt_d = '0;
              state_d   = ST_IDLE;
            end
          end else if (frame_tick) begin
            if (rpt_cnt == RPT_W'(1)) begin
              do_step   = 1'b1;
              step_up   = dir;
              rpt_cnt_d = RPT_W'(REPEAT_RATE);
              state_d   = ST_REPEAT;
            end else begin
              rpt_cnt_d = rpt_cnt - RPT_W'(1);
            end
          end
        end
        default: begin
          rpt_cnt_d = '0;
          state_d   = ST_IDLE;
        end
      endcase
    end
  end

  // Index datapath: apply a step with clamp or wrap at the ends.
  always_comb begin
    idx_d        = angle_idx;
    step_pulse_d = 1'b0;
    limit_hit_d  = 1'b0;
    if (press_home) begin
      idx_d = IDX_HOME;
    end else if (do_step) begin
      if (step_up) begin
        if (!at_top) begin
          idx_d        = angle_idx + IDX_W'(1);
          step_pulse_d = 1'b1;
        end else if (WRAP != 0) begin
          idx_d        = '0;
          step_pulse_d = 1'b1;
        end else begin
          limit_hit_d  = 1'b1;
        end
      end else begin
        if (!at_bottom) begin
          idx_d        = angle_idx - IDX_W'(1);
          step_pulse_d = 1'b1;
        end else if (WRAP != 0) begin
          idx_d        = IDX_TOP;
          step_pulse_d = 1'b1;
        end else begin
          limit_hit_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= ST_IDLE;
      dir        <= 1'b0;
      rpt_cnt    <= '0;
      key_prev   <= 8'h00;
      angle_idx  <= IDX_HOME;
      step_pulse <= 1'b0;
      limit_hit  <= 1'b0;
    end else begin
      state      <= state_d;
      dir        <= dir_d;
      rpt_cnt    <= rpt_cnt_d;
      key_prev   <= keycode;
      angle_idx  <= idx_d;
      step_pulse <= step_pulse_d;
      limit_hit  <= limit_hit_d;
    end
  end

  // Fire handshake: fire_valid holds with a stable fire_angle until an edge where
  // fire_valid && fire_ready; that edge completes the transfer and starts the cooldown.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fire_valid <= 1'b0;
      fire_angle <= '0;
      cooldown   <= '0;
    end else if (fire_valid && fire_ready) begin
      fire_valid <= 1'b0;
      cooldown   <= CD_W'(COOLDOWN);
    end else begin
      if (press_fire && !fire_valid && (cooldown == '0)) begin
        fire_valid <= 1'b1;
        fire_angle <= angle_idx;
      end
      if (frame_tick && (cooldown != '0)) begin
        cooldown <= cooldown - CD_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_turret_aim_ctrl.sv
// Bench for turret_aim_ctrl: a clamping and a wrapping instance share stimulus and
// are compared against an event-level model of the aiming and fire rules.
module tb_turret_aim_ctrl;

  localparam int NA    = 9;
  localparam int HOME  = 4;
  localparam int DELAY = 3;
  localparam int RATE  = 2;
  localparam int COOL  = 20;

  logic       Clk;
  logic       Reset;
  logic       frame_tick;
  logic [7:0] keycode;
  logic       fire_ready;

  logic [3:0] idx0, idx1, fang0, fang1;
  logic [8:0] oh0, oh1;
  logic       sp0, sp1, lh0, lh1, fv0, fv1;
  logic [1:0] st0, st1;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int   m_idx[2];
  bit   m_step[2];
  bit   m_lim[2];
  int   m_fangle[2];
  int   m_dir;      // 0 = no key held, +1 up, -1 down
  int   m_ticks;    // frame ticks seen while holding the current direction key
  bit   m_fvalid;
  int   m_cd;
  logic [7:0] m_prev;

  turret_aim_ctrl #(.WRAP(0), .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE), .COOLDOWN(COOL)) dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .keycode(keycode), .fire_ready(fire_ready),
    .angle_idx(idx0), .angle_onehot(oh0), .step_pulse(sp0), .limit_hit(lh0),
    .fire_valid(fv0), .fire_angle(fang0), .dbg_state(st0)
  );

  turret_aim_ctrl #(.WRAP(1), .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE), .COOLDOWN(COOL)) dut_w (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .keycode(keycode), .fire_ready(fire_ready),
    .angle_idx(idx1), .angle_onehot(oh1), .step_pulse(sp1), .limit_hit(lh1),
    .fire_valid(fv1), .fire_angle(fang1), .dbg_state(st1)
  );

  // Clock / reset
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      m_idx[w] = HOME; m_step[w] = 0; m_lim[w] = 0; m_fangle[w] = 0;
    end
    m_dir = 0; m_ticks = 0; m_fvalid = 0; m_cd = 0; m_prev = 8'h00;
  endtask

  task automatic model_move(input int d);
    int n;
    for (int w = 0; w < 2; w++) begin
      n = m_idx[w] + d;
      if (n < 0 || n >= NA) begin
        if (w == 1) begin
          m_idx[w] = (n < 0) ? NA - 1 : 0;
          m_step[w] = 1;
        end else begin
          m_lim[w] = 1;
        end
      end else begin
        m_idx[w] = n;
        m_step[w] = 1;
      end
    end
  endtask

  // One clock edge of the model, using the inputs as they stand before the edge.
  task automatic model_edge();
    bit p_up, p_dn, p_home, p_fire;
    logic [7:0] held_key, opp_key;
    if (!Reset) begin
      model_reset();
    end else begin
      p_up   = (keycode == 8'h1A) && (m_prev != 8'h1A);
      p_dn   = (keycode == 8'h16) && (m_prev != 8'h16);
      p_home = (keycode == 8'h4A) && (m_prev != 8'h4A);
      p_fire = (keycode == 8'h2C) && (m_prev != 8'h2C);
      for (int w = 0; w < 2; w++) begin m_step[w] = 0; m_lim[w] = 0; end
      if (m_fvalid && fire_ready) begin
        m_fvalid = 0;
        m_cd = COOL;
      end else begin
        if (p_fire && !m_fvalid && m_cd == 0) begin
          m_fvalid = 1;
          for (int w = 0; w < 2; w++) m_fangle[w] = m_idx[w];
        end
        if (frame_tick && m_cd > 0) m_cd--;
      end
      held_key = (m_dir > 0) ? 8'h1A : 8'h16;
      opp_key  = (m_dir > 0) ? 8'h16 : 8'h1A;
      if (p_home) begin
        for (int w = 0; w < 2; w++) m_idx[w] = HOME;
        m_dir = 0;
      end else if (m_dir == 0) begin
        if (p_up || p_dn) begin
          m_dir = p_up ? 1 : -1;
          m_ticks = 0;
          model_move(m_dir);
        end
      end else if (keycode == held_key) begin
        if (frame_tick) begin
          m_ticks++;
          if (m_ticks >= DELAY && ((m_ticks - DELAY) % RATE) == 0) model_move(m_dir);
        end
      end else if (keycode == opp_key && m_prev != opp_key) begin
        m_dir = -m_dir;
        m_ticks = 0;
        model_move(m_dir);
      end else begin
        m_dir = 0;
      end
      m_prev = keycode;
    end
  endtask

  // Driver: advance one clock; inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    model_edge();
    @(negedge Clk);
  endtask

  task automatic press(input logic [7:0] k);
    keycode = k; cyc();
    keycode = 8'h00; cyc();
  endtask

  task automatic test_reset();
    Reset = 1'b0; keycode = 8'h00; frame_tick = 1'b0; fire_ready = 1'b0;
    model_reset();
    cyc(); cyc();
    n_cmp++; if (idx0 !== 4'd4) begin n_bad++; $display("FAIL reset_idx: got %0d want 4", idx0); end
    n_cmp++; if (oh0 !== 9'b000010000) begin n_bad++; $display("FAIL reset_onehot: got %b want 000010000", oh0); end
    n_cmp++; if ({sp0, lh0, fv0} !== 3'b000) begin n_bad++; $display("FAIL reset_pulses: got %b want 000", {sp0, lh0, fv0}); end
    n_cmp++; if (fang0 !== 4'd0 || st0 !== 2'd0) begin n_bad++; $display("FAIL reset_fire_state: got angle %0d state %0d want 0 0", fang0, st0); end
    Reset = 1'b1;
    cyc();
  endtask

  task automatic test_single_step();
    keycode = 8'h1A; cyc();
    n_cmp++; if (idx0 !== 4'd5 || sp0 !== 1'b1) begin n_bad++; $display("FAIL single_step: got idx %0d pulse %0d want 5 1", idx0, sp0); end
    keycode = 8'h00; cyc();
    n_cmp++; if (oh0 !== 9'b000100000 || sp0 !== 1'b0) begin n_bad++; $display("FAIL single_onehot: got %b pulse %0d want 000100000 0", oh0, sp0); end
    n_cmp++; if (st0 !== 2'd0) begin n_bad++; $display("FAIL single_idle: got state %0d want 0", st0); end
    keycode = 8'h4A; cyc();
    n_cmp++; if (idx0 !== 4'd4 || sp0 !== 1'b0) begin n_bad++; $display("FAIL home: got idx %0d pulse %0d want 4 0", idx0, sp0); end
    keycode = 8'h00; cyc();
  endtask

  task automatic test_hold_repeat();
    int exp_i[10] = '{3, 3, 2, 2, 1, 1, 0, 0, 0, 0};
    keycode = 8'h16; cyc();
    n_cmp++; if (idx0 !== 4'd3 || sp0 !== 1'b1) begin n_bad++; $display("FAIL hold_press: got idx %0d pulse %0d want 3 1", idx0, sp0); end
    for (int k = 1; k <= 10; k++) begin
      frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
      n_cmp++;
      if (idx0 !== 4'(exp_i[k-1]) || sp0 !== (k == 3 || k == 5 || k == 7) || lh0 !== (k == 9)) begin
        n_bad++;
        $display("FAIL hold_tick%0d: got idx %0d step %0d limit %0d want %0d %0d %0d",
                 k, idx0, sp0, lh0, exp_i[k-1], (k == 3 || k == 5 || k == 7), (k == 9));
      end
      cyc();
    end
    n_cmp++; if (idx1 !== 4'd8) begin n_bad++; $display("FAIL hold_wrap_down: got %0d want 8", idx1); end
    keycode = 8'h00; cyc();
  endtask

  task automatic test_wrap();
    keycode = 8'h1A; cyc();
    n_cmp++; if (idx1 !== 4'd0 || sp1 !== 1'b1 || lh1 !== 1'b0) begin n_bad++; $display("FAIL wrap_up: got idx %0d step %0d limit %0d want 0 1 0", idx1, sp1, lh1); end
    keycode = 8'h00; cyc();
  endtask

  task automatic test_direction_switch();
    press(8'h4A);
    keycode = 8'h1A; cyc();
    frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
    keycode = 8'h16; cyc();
    n_cmp++; if (idx0 !== 4'd4 || sp0 !== 1'b1 || st0 !== 2'd1) begin n_bad++; $display("FAIL switch_step: got idx %0d step %0d state %0d want 4 1 1", idx0, sp0, st0); end
    for (int k = 1; k <= 3; k++) begin
      frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
      n_cmp++;
      if (idx0 !== ((k == 3) ? 4'd3 : 4'd4)) begin n_bad++; $display("FAIL switch_reload_tick%0d: got %0d want %0d", k, idx0, (k == 3) ? 3 : 4); end
      cyc();
    end
    keycode = 8'h00; cyc();
  endtask

  task automatic test_fire();
    press(8'h4A); press(8'h1A); press(8'h1A);
    fire_ready = 1'b0;
    keycode = 8'h2C; cyc(); keycode = 8'h00;
    repeat (5) cyc();
    n_cmp++; if (fv0 !== 1'b1 || fang0 !== 4'd6) begin n_bad++; $display("FAIL fire_hold: got valid %0d angle %0d want 1 6", fv0, fang0); end
    press(8'h1A);
    n_cmp++; if (idx0 !== 4'd7 || fang0 !== 4'd6 || fv0 !== 1'b1) begin n_bad++; $display("FAIL fire_stable: got idx %0d angle %0d valid %0d want 7 6 1", idx0, fang0, fv0); end
    fire_ready = 1'b1; cyc(); fire_ready = 1'b0;
    n_cmp++; if (fv0 !== 1'b0) begin n_bad++; $display("FAIL fire_accept: got valid %0d want 0", fv0); end
    press(8'h2C);
    n_cmp++; if (fv0 !== 1'b0) begin n_bad++; $display("FAIL fire_cooldown_early: got valid %0d want 0", fv0); end
    repeat (19) begin frame_tick = 1'b1; cyc(); frame_tick = 1'b0; cyc(); end
    press(8'h2C);
    n_cmp++; if (fv0 !== 1'b0) begin n_bad++; $display("FAIL fire_cooldown_last: got valid %0d want 0", fv0); end
    frame_tick = 1'b1; cyc(); frame_tick = 1'b0; cyc();
    press(8'h2C);
    n_cmp++; if (fv0 !== 1'b1 || fang0 !== 4'd7) begin n_bad++; $display("FAIL fire_after_cooldown: got valid %0d angle %0d want 1 7", fv0, fang0); end
  endtask

  task automatic test_reset_mid_repeat();
    press(8'h4A);
    keycode = 8'h16; cyc();
    repeat (5) begin frame_tick = 1'b1; cyc(); frame_tick = 1'b0; cyc(); end
    n_cmp++; if (idx0 !== 4'd1 || st0 !== 2'd2 || fv0 !== 1'b1) begin n_bad++; $display("FAIL pre_reset: got idx %0d state %0d valid %0d want 1 2 1", idx0, st0, fv0); end
    #2 Reset = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (idx0 !== 4'd4 || fv0 !== 1'b0 || st0 !== 2'd0 || oh0 !== 9'b000010000) begin
      n_bad++; $display("FAIL async_reset: got idx %0d valid %0d state %0d onehot %b want 4 0 0 000010000", idx0, fv0, st0, oh0);
    end
    cyc();
    Reset = 1'b1;
    cyc();
    n_cmp++; if (idx0 !== 4'd3 || sp0 !== 1'b1) begin n_bad++; $display("FAIL held_through_reset: got idx %0d step %0d want 3 1", idx0, sp0); end
    cyc(); cyc();
    n_cmp++; if (idx0 !== 4'd3 || sp0 !== 1'b0) begin n_bad++; $display("FAIL held_single_step: got idx %0d step %0d want 3 0", idx0, sp0); end
    keycode = 8'h00; cyc();
  endtask

  task automatic test_random();
    int r, hold;
    logic [3:0] a_idx[2], a_fang[2];
    logic [8:0] a_oh[2];
    logic       a_sp[2], a_lh[2], a_fv[2];
    logic [1:0] a_st[2];
    int exp_st;
    for (int t = 0; t < 250; t++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: keycode = 8'h1A;
        3, 4, 5: keycode = 8'h16;
        6:       keycode = 8'h4A;
        7:       keycode = 8'h2C;
        8:       keycode = 8'h00;
        default: keycode = 8'($urandom_range(0, 255));
      endcase
      hold = $urandom_range(1, 12);
      for (int c = 0; c < hold; c++) begin
        frame_tick = ($urandom_range(0, 2) == 0);
        fire_ready = ($urandom_range(0, 3) == 0);
        cyc();
        a_idx = '{idx0, idx1}; a_fang = '{fang0, fang1}; a_oh = '{oh0, oh1};
        a_sp = '{sp0, sp1}; a_lh = '{lh0, lh1}; a_fv = '{fv0, fv1}; a_st = '{st0, st1};
        exp_st = (m_dir == 0) ? 0 : ((m_ticks < DELAY) ? 1 : 2);
        for (int w = 0; w < 2; w++) begin
          n_cmp++;
          if (a_idx[w] !== 4'(m_idx[w]) || a_oh[w] !== (9'd1 << m_idx[w]) || a_sp[w] !== m_step[w] ||
              a_lh[w] !== m_lim[w] || a_fv[w] !== m_fvalid || a_st[w] !== 2'(exp_st) ||
              (m_fvalid && a_fang[w] !== 4'(m_fangle[w]))) begin
            n_bad++;
            $display("FAIL random_w%0d t=%0t: got idx %0d oh %b sp %0d lh %0d fv %0d fa %0d st %0d want %0d %b %0d %0d %0d %0d %0d",
                     w, $time, a_idx[w], a_oh[w], a_sp[w], a_lh[w], a_fv[w], a_fang[w], a_st[w],
                     m_idx[w], 9'd1 << m_idx[w], m_step[w], m_lim[w], m_fvalid, m_fangle[w], exp_st);
          end
        end
      end
    end
    keycode = 8'h00; frame_tick = 1'b0; fire_ready = 1'b0; cyc();
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_hold_repeat();
    test_wrap();
    test_direction_switch();
    test_fire();
    test_reset_mid_repeat();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
